// File: rtl/tap_pkg.sv
// Shared TAP state encodings, opcode constants and DR select type.
// The IDCODE data register is built only when TAP_IDCODE_EN is defined.
package tap_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PAU_DR = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PAU_IR = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_e;

  // BYPASS is all-ones at whatever IR width the TAP is built with.
  localparam int OP_IDCODE = 1;
  localparam int OP_USER   = 2;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2
  } dr_sel_e;

endpackage

// File: rtl/tap_state_fsm.sv
// IEEE 1149.1 TAP controller state register and next-state graph.
// next_state is exported so the datapath can act on entry into Test-Logic-Reset.
module tap_state_fsm
  import tap_pkg::*;
(
  input  logic       TCLK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_e state,
  output tap_state_e next_state
);

  always_comb begin
    next_state = TLR;
    case (state)
      TLR:    next_state = TMS ? TLR    : RTI;
      RTI:    next_state = TMS ? SEL_DR : RTI;
      SEL_DR: next_state = TMS ? SEL_IR : CAP_DR;
      CAP_DR: next_state = TMS ? EX1_DR : SH_DR;
      SH_DR:  next_state = TMS ? EX1_DR : SH_DR;
      EX1_DR: next_state = TMS ? UPD_DR : PAU_DR;
      PAU_DR: next_state = TMS ? EX2_DR : PAU_DR;
      EX2_DR: next_state = TMS ? UPD_DR : SH_DR;
      UPD_DR: next_state = TMS ? SEL_DR : RTI;
      SEL_IR: next_state = TMS ? TLR    : CAP_IR;
      CAP_IR: next_state = TMS ? EX1_IR : SH_IR;
      SH_IR:  next_state = TMS ? EX1_IR : SH_IR;
      EX1_IR: next_state = TMS ? UPD_IR : PAU_IR;
      PAU_IR: next_state = TMS ? EX2_IR : PAU_IR;
      EX2_IR: next_state = TMS ? UPD_IR : SH_IR;
      UPD_IR: next_state = TMS ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  end

  always_ff @(posedge TCLK or negedge TRST) begin
    if (!TRST) begin
      state <= TLR;
    end else begin
      state <= next_state;
    end
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller with IR, BYPASS and USER data registers.
// Define TAP_IDCODE_EN to add the 32-bit IDCODE register and make IDCODE the reset instruction.
module jtag_tap_ctrl
  import tap_pkg::*;
#(
  parameter int          IR_LEN     = 4,
  parameter int          USER_LEN   = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic                TCLK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_EN,
  output logic [3:0]          state_out,
  output logic [IR_LEN-1:0]   ir_out,
  input  logic [USER_LEN-1:0] user_cap_in,
  output logic [USER_LEN-1:0] user_upd_out,
  output logic                user_upd_stb
);

  if (IR_LEN < 2 || USER_LEN < 1 || IDCODE_VAL[0] != 1'b1) begin : g_bad_params
    $error("jtag_tap_ctrl: illegal parameter set");
  end

  localparam logic [IR_LEN-1:0] IR_BYPASS  = '1;
  localparam logic [IR_LEN-1:0] IR_USER    = IR_LEN'(OP_USER);
  localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(2'b01);
`ifdef TAP_IDCODE_EN
  localparam logic [IR_LEN-1:0] IR_IDCODE  = IR_LEN'(OP_IDCODE);
  localparam logic [IR_LEN-1:0] IR_RESET   = IR_IDCODE;
`else
  localparam logic [IR_LEN-1:0] IR_RESET   = IR_BYPASS;
`endif

  tap_state_e state;
  tap_state_e next_state;

  logic [IR_LEN-1:0]   ir_sr;
  logic                bypass_sr;
  logic [USER_LEN-1:0] user_sr;
  dr_sel_e             dr_sel;
  logic                dr_lsb;

  tap_state_fsm u_fsm (
    .TCLK       (TCLK),
    .TRST       (TRST),
    .TMS        (TMS),
    .state      (state),
    .next_state (next_state)
  );

  assign state_out = state;

  // Unknown opcodes, including the explicit all-ones one, fall through to BYPASS.
  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir_out == IR_USER) dr_sel = DR_USER;
`ifdef TAP_IDCODE_EN
    else if (ir_out == IR_IDCODE) dr_sel = DR_IDCODE;
`endif
  end

  always_ff @(posedge TCLK or negedge TRST) begin
    if (!TRST) begin
      ir_sr  <= '0;
      ir_out <= IR_RESET;
    end else begin
      case (state)
        CAP_IR: ir_sr <= IR_CAPTURE;
        SH_IR:  ir_sr <= (ir_sr >> 1) | (IR_LEN'(TDI) << (IR_LEN - 1));
        default: ;
      endcase
      // Reload on entry into (and while in) TLR so the reset instruction is live immediately.
      if (next_state == TLR) begin
        ir_out <= IR_RESET;
      end else if (state == UPD_IR) begin
        ir_out <= ir_sr;
      end
    end
  end

  always_ff @(posedge TCLK or negedge TRST) begin
    if (!TRST) begin
      bypass_sr    <= 1'b0;
      user_sr      <= '0;
      user_upd_out <= '0;
      user_upd_stb <= 1'b0;
    end else begin
      user_upd_stb <= 1'b0;
      if (dr_sel == DR_BYPASS) begin
        case (state)
          CAP_DR: bypass_sr <= 1'b0;
          SH_DR:  bypass_sr <= TDI;
          default: ;
        endcase
      end
      if (dr_sel == DR_USER) begin
        case (state)
          CAP_DR: user_sr <= user_cap_in;
          SH_DR:  user_sr <= (user_sr >> 1) | (USER_LEN'(TDI) << (USER_LEN - 1));
          UPD_DR: begin
            user_upd_out <= user_sr;
            user_upd_stb <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TAP_IDCODE_EN
  logic [31:0] idcode_sr;

  always_ff @(posedge TCLK or negedge TRST) begin
    if (!TRST) begin
      idcode_sr <= '0;
    end else if (dr_sel == DR_IDCODE) begin
      case (state)
        CAP_DR: idcode_sr <= IDCODE_VAL;
        SH_DR:  idcode_sr <= {TDI, idcode_sr[31:1]};
        default: ;
      endcase
    end
  end
`endif

  always_comb begin
    dr_lsb = bypass_sr;
    case (dr_sel)
      DR_USER:   dr_lsb = user_sr[0];
`ifdef TAP_IDCODE_EN
      DR_IDCODE: dr_lsb = idcode_sr[0];
`endif
      default:   dr_lsb = bypass_sr;
    endcase
  end

  // TDO moves on the falling edge so the host samples a stable bit on the next rising edge.
  always_ff @(negedge TCLK or negedge TRST) begin
    if (!TRST) begin
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end else begin
      TDO    <= (state == SH_IR) ? ir_sr[0] : ((state == SH_DR) ? dr_lsb : 1'b0);
      TDO_EN <= (state == SH_IR) || (state == SH_DR);
    end
  end

endmodule

// File: doc/jtag_tap_ctrl.md
JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 SHALL have parameter IR_LEN, default 4, instruction register width (>=2).
REQ-002 SHALL have parameter USER_LEN, default 8, user data register width (>=1).
REQ-003 SHALL have parameter IDCODE_VAL, default 32'h1000_0001, 32-bit device ID (bit0 must be 1).
REQ-004 SHALL have port TCLK  input  1  sole clock; all flops on TCLK edges.
REQ-005 SHALL have port TRST  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port TMS  input  1  mode select, sampled on TCLK rising edge.
REQ-007 SHALL have port TDI  input  1  serial data in, sampled on TCLK rising edge.
REQ-008 SHALL have port TDO  output  1  serial data out, updated on TCLK falling edge.
REQ-009 SHALL have port TDO_EN  output  1  high while TDO is valid (Shift-DR/Shift-IR).
REQ-010 SHALL have port state_out  output  4  current TAP state encoding.
REQ-011 SHALL have port ir_out  output  IR_LEN  current (updated) instruction.
REQ-012 SHALL have port user_cap_in  input  USER_LEN  parallel capture data for USER register.
REQ-013 SHALL have port user_upd_out  output  USER_LEN  parallel update data from USER register.
REQ-014 SHALL have port user_upd_stb  output  1  one-TCLK pulse when user_upd_out is loaded.

Function
REQ-015 SHALL implement the 16-state IEEE 1149.1 TAP graph, state register updated on TCLK rising edge.
REQ-016 Transitions (TMS=0/TMS=1) SHALL be: TLR->RTI/TLR; RTI->RTI/SelDR; SelDR->CapDR/SelIR; CapDR->ShDR/Ex1DR; ShDR->ShDR/Ex1DR; Ex1DR->PauDR/UpdDR; PauDR->PauDR/Ex2DR; Ex2DR->ShDR/UpdDR; UpdDR->RTI/SelDR; IR branch identical with SelIR TMS=1 ->TLR.
REQ-017 Five consecutive TMS=1 rising edges SHALL reach TLR from any state.
REQ-018 Capture-IR SHALL load IR shift register with {IR_LEN-2 zeros, 2'b01}.
REQ-019 Shift-IR/Shift-DR SHALL shift LSB-first: TDI enters MSB, LSB drives TDO.
REQ-020 Update-IR SHALL copy IR shift register to ir_out on TCLK rising edge leaving Update-IR... precisely: in the cycle the state is Update-IR, ir_out loads at the next rising edge.
REQ-021 Opcodes SHALL be: all-ones BYPASS, 1 IDCODE, 2 USER; any other opcode SHALL select BYPASS.
REQ-022 BYPASS DR SHALL be 1 bit, captured as 0.
REQ-023 IDCODE DR SHALL be 32 bits, captured as IDCODE_VAL.
REQ-024 USER DR SHALL capture user_cap_in in Capture-DR; Update-DR SHALL load user_upd_out and assert user_upd_stb for exactly one cycle; no strobe for other instructions.
REQ-025 DR registers not selected by ir_out SHALL hold their contents.
REQ-026 TDO SHALL be 0 and TDO_EN 0 outside Shift states; TDO_EN SHALL change on falling edge with TDO.
REQ-027 Pause/Exit states SHALL hold shift register contents unchanged.

Reset
REQ-028 TRST low SHALL force immediately: state TLR (4'd0), ir_out to reset instruction, all shift registers 0, user_upd_out 0, user_upd_stb 0, TDO 0, TDO_EN 0.
REQ-029 Entering TLR via TMS SHALL also reload ir_out with the reset instruction; user_upd_out SHALL be kept.
REQ-030 TRST asserted mid-shift SHALL abort with no update or strobe.

Configuration
REQ-031 With TAP_IDCODE_EN defined: IDCODE DR present, reset instruction = IDCODE (1).
REQ-032 Without TAP_IDCODE_EN: no IDCODE register, reset instruction = BYPASS, opcode 1 decodes as BYPASS.

Structure
REQ-033 Package tap_pkg SHALL hold state encodings (TLR=0, RTI=1, SelDR=2, CapDR=3, ShDR=4, Ex1DR=5, PauDR=6, Ex2DR=7, UpdDR=8, SelIR=9, CapIR=10, ShIR=11, Ex1IR=12, PauIR=13, Ex2IR=14, UpdIR=15) and opcode constants.
REQ-034 Sub-module tap_state_fsm SHALL contain the state register and next-state logic only.

Verification
REQ-035 TRST pulse, then TMS=0 x1 -> state_out=1 (RTI), ir_out=1 (IDCODE_EN) or 4'hF.
REQ-036 From reset, shift 32 DR bits -> TDO stream equals 32'h1000_0001 LSB-first.
REQ-037 Load IR=4'h2, Capture-DR with user_cap_in=8'hA5, shift in 8'h3C -> TDO yields A5, user_upd_out=8'h3C, one strobe pulse.
REQ-038 IR=4'h7, shift 1-bit pattern 1,0,1 through DR -> TDO delayed by one bit; capture-IR readout = 4'b0001.
REQ-039 From Pause-DR apply TMS=1 x5 -> state_out=0, ir_out=reset instruction, user_upd_out unchanged.
REQ-040 TRST low mid-Shift-DR under USER -> state 0, no user_upd_stb, TDO_EN=0.
